lcd_bus_responder: RTL and testbench

//  HD44780-compatible responder for the 8-bit LCD bus: the controller-side end of the bus our LCD writer drives.

---
 rtl/lcd_bus_responder.sv | 197 +++++++++++++++++++
 tb/tb_lcd_bus_responder.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_bus_responder.sv
// HD44780-compatible responder for the 8-bit LCD bus.
// Keeps a 2x16 character buffer, busy flag, and display-control bits.
module lcd_bus_responder #(
   parameter int BUSY_CYCLES = 2000,
   parameter int CLR_CYCLES  = 82000
) (
   input  logic       I_CLK,
   input  logic       I_RST,
   input  logic       I_LCD_ON,
   input  logic       I_LCD_EN,
   input  logic       I_LCD_RS,
   input  logic       I_LCD_RWF,
   input  logic [7:0] I_LCD_DATA,
   output logic [7:0] O_LCD_DATA,
   output logic       O_LCD_DATA_OE,
   output logic       O_BUSY,
   output logic       O_DISP_ON,
   output logic       O_CURSOR,
   output logic       O_BLINK,
   output logic       O_WR_VALID,
   output logic [4:0] O_WR_IDX,
   output logic [7:0] O_WR_DATA,
   output logic       O_PROTO_ERR,
   input  logic [4:0] I_RD_IDX,
   output logic [7:0] O_RD_CHAR
);

   localparam int MAXC = (CLR_CYCLES > BUSY_CYCLES) ? CLR_CYCLES : BUSY_CYCLES;
   localparam int CW   = $clog2(MAXC + 1);

   logic [2:0]    en_q;
   logic [1:0]    rs_q;
   logic [1:0]    rwf_q;
   logic [7:0]    d1_q;
   logic [7:0]    d2_q;
   logic [CW-1:0] cnt_q;
   logic [6:0]    ac_q;
   logic          id_q;
   logic [2:0]    dcb_q;
   logic [7:0]    rdat_q;
   logic [7:0]    buf_q [32];

   logic          strobe;
   logic          rise;
   logic          stat_rd;
   logic          accept;
   logic          proto;
   logic          mapped;
   logic [4:0]    map_idx;
   logic [7:0]    ac_char;

   logic [6:0]    ac_d;
   logic          id_d;
   logic [2:0]    dcb_d;
   logic          ld;
   logic [CW-1:0] ld_val;
   logic          wr;
   logic          clr;

   function automatic logic [6:0] ac_step(input logic [6:0] a, input logic inc);
      logic [6:0] r;
      if (inc) begin
         if (a == 7'h27)      r = 7'h40;
         else if (a == 7'h67) r = 7'h00;
         else                 r = a + 7'd1;
      end else begin
         if (a == 7'h00)      r = 7'h67;
         else if (a == 7'h40) r = 7'h27;
         else                 r = a - 7'd1;
      end
      return r;
   endfunction

   assign strobe  = I_LCD_ON & en_q[2] & ~en_q[1];
   assign rise    = en_q[1] & ~en_q[2];
   assign stat_rd = ~rs_q[1] & rwf_q[1];
   assign O_BUSY  = (cnt_q != '0);
   assign accept  = strobe & (~O_BUSY | stat_rd);
   assign proto   = strobe & O_BUSY & ~stat_rd;
   assign mapped  = (ac_q[5:4] == 2'b00);
   assign map_idx = {ac_q[6], ac_q[3:0]};
   assign ac_char = mapped ? buf_q[map_idx] : 8'h20;

   assign O_LCD_DATA_OE = en_q[1] & rwf_q[1] & I_LCD_ON;
   assign O_LCD_DATA    = O_LCD_DATA_OE ? rdat_q : 8'h00;
   assign O_DISP_ON     = dcb_q[2];
   assign O_CURSOR      = dcb_q[1];
   assign O_BLINK       = dcb_q[0];

   // Decode the access taken at the strobe into next-state updates.
   always_comb begin
      ac_d   = ac_q;
      id_d   = id_q;
      dcb_d  = dcb_q;
      ld     = 1'b0;
      ld_val = CW'(BUSY_CYCLES);
      wr     = 1'b0;
      clr    = 1'b0;
      if (accept) begin
         unique case ({rs_q[1], rwf_q[1]})
            2'b00: begin
               unique casez (d2_q)
                  8'b1???????: begin
                     ld   = 1'b1;
                     ac_d = d2_q[6:0];
                  end
                  8'b01??????, 8'b001?????: ld = 1'b1;
                  8'b0001????: begin
                     ld = 1'b1;
                     if (!d2_q[3]) ac_d = ac_step(ac_q, d2_q[2]);
                  end
                  8'b00001???: begin
                     ld    = 1'b1;
                     dcb_d = d2_q[2:0];
                  end
                  8'b000001??: begin
                     ld   = 1'b1;
                     id_d = d2_q[1];
                  end
                  8'b0000001?: begin
                     ld     = 1'b1;
                     ld_val = CW'(CLR_CYCLES);
                     ac_d   = 7'h00;
                  end
                  8'b00000001: begin
                     ld     = 1'b1;
                     ld_val = CW'(CLR_CYCLES);
                     ac_d   = 7'h00;
                     id_d   = 1'b1;
                     clr    = 1'b1;
                  end
                  default: ;
               endcase
            end
            2'b10: begin
               ld   = 1'b1;
               wr   = mapped;
               ac_d = ac_step(ac_q, id_q);
            end
            2'b11: begin
               ld   = 1'b1;
               ac_d = ac_step(ac_q, id_q);
            end
            default: ;
         endcase
      end
   end

   // Bus synchronizer, controller state, character buffer and output pulses.
   always_ff @(posedge I_CLK) begin
      if (I_RST) begin
         en_q        <= '0;
         rs_q        <= '0;
         rwf_q       <= '0;
         d1_q        <= '0;
         d2_q        <= '0;
         cnt_q       <= '0;
         ac_q        <= '0;
         id_q        <= 1'b1;
         dcb_q       <= '0;
         rdat_q      <= '0;
         O_WR_VALID  <= 1'b0;
         O_WR_IDX    <= '0;
         O_WR_DATA   <= '0;
         O_PROTO_ERR <= 1'b0;
         O_RD_CHAR   <= '0;
         for (int i = 0; i < 32; i++) buf_q[i] <= 8'h20;
      end else begin
         en_q        <= {en_q[1:0], I_LCD_EN};
         rs_q        <= {rs_q[0], I_LCD_RS};
         rwf_q       <= {rwf_q[0], I_LCD_RWF};
         d1_q        <= I_LCD_DATA;
         d2_q        <= d1_q;
         ac_q        <= ac_d;
         id_q        <= id_d;
         dcb_q       <= dcb_d;
         O_WR_VALID  <= wr;
         O_PROTO_ERR <= proto;
         O_RD_CHAR   <= buf_q[I_RD_IDX];
         if (ld)
            cnt_q <= ld_val;
         else if (O_BUSY && I_LCD_ON)
            cnt_q <= cnt_q - 1'b1;
         if (rise)
            rdat_q <= rs_q[1] ? ac_char : {O_BUSY, ac_q};
         if (wr) begin
            O_WR_IDX  <= map_idx;
            O_WR_DATA <= d2_q;
         end
         if (clr)
            for (int i = 0; i < 32; i++) buf_q[i] <= 8'h20;
         else if (wr)
            buf_q[map_idx] <= d2_q;
      end
   end

endmodule

// File: tb/tb_lcd_bus_responder.sv
// Directed bench for lcd_bus_responder.
// Table of command/data writes with expected AC and D/C/B, plus corner sequences.
module tb_lcd_bus_responder;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       lcd_on = 1'b1;
   logic       en_i = 1'b0;
   logic       rs_i = 1'b0;
   logic       rwf_i = 1'b0;
   logic [7:0] data_i = 8'h00;
   logic [4:0] rd_idx = 5'd0;
   logic [7:0] lcd_data;
   logic       lcd_oe;
   logic       busy;
   logic       disp_on;
   logic       cursor;
   logic       blink;
   logic       wr_valid;
   logic [4:0] wr_idx;
   logic [7:0] wr_data;
   logic       proto_err;
   logic [7:0] rd_char;

   int errors = 0;
   int checks = 0;
   int wr_cnt = 0;
   int pe_cnt = 0;
   logic [4:0] last_idx = '0;
   logic [7:0] last_dat = '0;

   always #5 clk = ~clk;

   lcd_bus_responder #(.BUSY_CYCLES(20), .CLR_CYCLES(100)) dut (
      .I_CLK(clk),
      .I_RST(rst),
      .I_LCD_ON(lcd_on),
      .I_LCD_EN(en_i),
      .I_LCD_RS(rs_i),
      .I_LCD_RWF(rwf_i),
      .I_LCD_DATA(data_i),
      .O_LCD_DATA(lcd_data),
      .O_LCD_DATA_OE(lcd_oe),
      .O_BUSY(busy),
      .O_DISP_ON(disp_on),
      .O_CURSOR(cursor),
      .O_BLINK(blink),
      .O_WR_VALID(wr_valid),
      .O_WR_IDX(wr_idx),
      .O_WR_DATA(wr_data),
      .O_PROTO_ERR(proto_err),
      .I_RD_IDX(rd_idx),
      .O_RD_CHAR(rd_char)
   );

   // Count write and protocol-error pulses.
   always @(negedge clk) begin
      if (wr_valid) begin
         wr_cnt++;
         last_idx = wr_idx;
         last_dat = wr_data;
      end
      if (proto_err) pe_cnt++;
   end

   typedef struct {
      logic       rs;
      logic [7:0] d;
      logic [6:0] ac;
      logic [2:0] dcb;
   } vec_t;

   vec_t tbl[26];

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic bus(input logic rs, input logic rwf, input logic [7:0] d,
                      output logic [7:0] rd, output logic oe);
      @(negedge clk);
      rs_i = rs;
      rwf_i = rwf;
      data_i = d;
      @(negedge clk);
      en_i = 1'b1;
      repeat (4) @(negedge clk);
      oe = lcd_oe;
      rd = lcd_data;
      en_i = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (busy) begin
         checks++;
         errors++;
         $display("FAIL idle_timeout: busy still %0d", busy);
      end
   endtask

   task automatic rd_buf(input int idx, output logic [7:0] c);
      @(negedge clk);
      rd_idx = 5'(idx);
      @(negedge clk);
      c = rd_char;
   endtask

   initial begin
      logic [7:0] rd;
      logic       oe;
      logic [7:0] c;
      int         w0;
      int         p0;

      tbl[0]  = '{1'b0, 8'h38, 7'h00, 3'b000};
      tbl[1]  = '{1'b0, 8'h0F, 7'h00, 3'b111};
      tbl[2]  = '{1'b0, 8'h01, 7'h00, 3'b111};
      tbl[3]  = '{1'b0, 8'h06, 7'h00, 3'b111};
      tbl[4]  = '{1'b0, 8'hA7, 7'h27, 3'b111};
      tbl[5]  = '{1'b1, "x",   7'h40, 3'b111};
      tbl[6]  = '{1'b0, 8'h04, 7'h40, 3'b111};
      tbl[7]  = '{1'b0, 8'h80, 7'h00, 3'b111};
      tbl[8]  = '{1'b1, "y",   7'h67, 3'b111};
      tbl[9]  = '{1'b0, 8'h06, 7'h67, 3'b111};
      tbl[10] = '{1'b0, 8'hC0, 7'h40, 3'b111};
      tbl[11] = '{1'b0, 8'h10, 7'h27, 3'b111};
      tbl[12] = '{1'b0, 8'h14, 7'h40, 3'b111};
      tbl[13] = '{1'b0, 8'h18, 7'h40, 3'b111};
      tbl[14] = '{1'b0, 8'hE7, 7'h67, 3'b111};
      tbl[15] = '{1'b0, 8'h14, 7'h00, 3'b111};
      tbl[16] = '{1'b0, 8'h85, 7'h05, 3'b111};
      tbl[17] = '{1'b0, 8'h02, 7'h00, 3'b111};
      tbl[18] = '{1'b0, 8'h08, 7'h00, 3'b000};
      tbl[19] = '{1'b0, 8'h0D, 7'h00, 3'b101};
      tbl[20] = '{1'b0, 8'h7F, 7'h00, 3'b101};
      tbl[21] = '{1'b0, 8'h3F, 7'h00, 3'b101};
      tbl[22] = '{1'b0, 8'hD0, 7'h50, 3'b101};
      tbl[23] = '{1'b0, 8'h14, 7'h51, 3'b101};
      tbl[24] = '{1'b1, "z",   7'h52, 3'b101};
      tbl[25] = '{1'b0, 8'h0F, 7'h52, 3'b111};

      // reset state
      repeat (3) @(negedge clk);
      chk("rst_rd_char", rd_char, 8'h00);
      chk("rst_busy", busy, 0);
      chk("rst_oe", lcd_oe, 0);
      rst = 1'b0;
      chk("rst_dcb", {disp_on, cursor, blink}, 0);
      for (int i = 0; i < 32; i++) begin
         rd_buf(i, c);
         chk($sformatf("rst_buf%0d", i), c, 8'h20);
      end

      // table: write, busy seen, wait idle, status read
      for (int i = 0; i < 26; i++) begin
         bus(tbl[i].rs, 1'b0, tbl[i].d, rd, oe);
         chk($sformatf("tbl%0d_busy", i), busy, 1);
         wait_idle();
         bus(1'b0, 1'b1, 8'h00, rd, oe);
         chk($sformatf("tbl%0d_ac", i), rd, {1'b0, tbl[i].ac});
         chk($sformatf("tbl%0d_dcb", i), {disp_on, cursor, blink}, tbl[i].dcb);
      end
      chk("tbl_wr_cnt", wr_cnt, 1);
      chk("tbl_pe_cnt", pe_cnt, 0);
      rd_buf(0, c);
      chk("tbl_buf0_y", c, "y");

      // null command does not load busy
      bus(1'b0, 1'b0, 8'h00, rd, oe);
      chk("nop_busy", busy, 0);

      // fill both lines
      w0 = wr_cnt;
      bus(1'b0, 1'b0, 8'h80, rd, oe);
      wait_idle();
      for (int i = 0; i < 16; i++) begin
         bus(1'b1, 1'b0, 8'(8'h41 + i), rd, oe);
         wait_idle();
      end
      bus(1'b0, 1'b0, 8'hC0, rd, oe);
      wait_idle();
      for (int i = 0; i < 16; i++) begin
         bus(1'b1, 1'b0, 8'(8'h61 + i), rd, oe);
         wait_idle();
      end
      chk("fill_wr_cnt", wr_cnt - w0, 32);
      chk("fill_last_idx", last_idx, 31);
      chk("fill_last_dat", last_dat, "p");
      rd_buf(0, c);
      chk("fill_idx0", c, "A");
      rd_buf(15, c);
      chk("fill_idx15", c, "P");
      rd_buf(16, c);
      chk("fill_idx16", c, "a");
      rd_buf(31, c);
      chk("fill_idx31", c, "p");

      // access while busy after clear
      w0 = wr_cnt;
      p0 = pe_cnt;
      bus(1'b0, 1'b0, 8'h01, rd, oe);
      repeat (10) @(negedge clk);
      bus(1'b1, 1'b0, "K", rd, oe);
      chk("busy_pe", pe_cnt - p0, 1);
      chk("busy_wr", wr_cnt - w0, 0);
      bus(1'b0, 1'b1, 8'h00, rd, oe);
      chk("busy_stat", rd, 8'h80);
      wait_idle();
      bus(1'b0, 1'b1, 8'h00, rd, oe);
      chk("idle_stat", rd, 8'h00);
      rd_buf(0, c);
      chk("clr_idx0", c, 8'h20);
      rd_buf(31, c);
      chk("clr_idx31", c, 8'h20);

      // data read
      bus(1'b0, 1'b0, 8'h85, rd, oe);
      wait_idle();
      bus(1'b1, 1'b0, "Q", rd, oe);
      wait_idle();
      bus(1'b0, 1'b0, 8'h85, rd, oe);
      wait_idle();
      bus(1'b1, 1'b1, 8'h00, rd, oe);
      chk("drd_oe", oe, 1);
      chk("drd_data", rd, "Q");
      chk("drd_busy", busy, 1);
      wait_idle();
      bus(1'b0, 1'b1, 8'h00, rd, oe);
      chk("drd_ac", rd, 8'h06);
      chk("oe_low", lcd_oe, 0);
      chk("data_low", lcd_data, 8'h00);
      bus(1'b0, 1'b0, 8'h90, rd, oe);
      wait_idle();
      bus(1'b1, 1'b1, 8'h00, rd, oe);
      chk("drd_offscreen", rd, 8'h20);
      wait_idle();

      // panel off ignores bus
      w0 = wr_cnt;
      lcd_on = 1'b0;
      bus(1'b0, 1'b0, 8'h80, rd, oe);
      bus(1'b1, 1'b0, "W", rd, oe);
      chk("off_wr", wr_cnt - w0, 0);
      chk("off_busy", busy, 0);
      bus(1'b0, 1'b1, 8'h00, rd, oe);
      chk("off_oe", oe, 0);
      lcd_on = 1'b1;
      bus(1'b0, 1'b1, 8'h00, rd, oe);
      chk("on_ac_held", rd, 8'h11);

      // reset mid-busy
      bus(1'b0, 1'b0, 8'h01, rd, oe);
      repeat (3) @(negedge clk);
      chk("mid_busy", busy, 1);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_dcb", {disp_on, cursor, blink}, 0);
      rst = 1'b0;

      // reset mid-EN pulse discards the pending strobe
      w0 = wr_cnt;
      p0 = pe_cnt;
      rs_i = 1'b1;
      rwf_i = 1'b0;
      data_i = "Z";
      @(negedge clk);
      en_i = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      en_i = 1'b0;
      repeat (6) @(negedge clk);
      chk("en_rst_wr", wr_cnt - w0, 0);
      chk("en_rst_pe", pe_cnt - p0, 0);
      chk("en_rst_busy", busy, 0);
      rd_buf(0, c);
      chk("en_rst_buf0", c, 8'h20);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
